// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill-level status flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is registered pop.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   almost_full_th,
  input  logic [ADDR_WIDTH:0]   almost_empty_th,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  half_full,
  output logic                  half_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] HALF_LVL = {2'b01, {(ADDR_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_acc, rd_acc;
  logic [ADDR_WIDTH:0] count_w;

  // Extra pointer MSB distinguishes full from empty; subtraction stays correct across wrap.
  assign count_w = wr_ptr_q - rd_ptr_q;

  assign full         = (count_w == FULL_LVL);
  assign empty        = (count_w == '0);
  assign half_full    = (count_w >= HALF_LVL);
  assign half_empty   = (count_w <  HALF_LVL);
  assign almost_full  = (count_w >= almost_full_th);
  assign almost_empty = (count_w <= almost_empty_th);
  assign count        = count_w;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
    overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        data_out_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed plus randomized bench for sync_fifo_ctrl (DEPTH=16) against a queue-based model.
module tb_sync_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [AW:0]   af_th;
  logic [AW:0]   ae_th;
  logic          clr_err;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full, empty, half_full, half_empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .almost_full_th(af_th), .almost_empty_th(ae_th), .clr_err(clr_err),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .half_full(half_full), .half_empty(half_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_rv, exp_ovf, exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("half_full", 32'(half_full), 32'(n >= DEPTH/2));
    check("half_empty", 32'(half_empty), 32'(n < DEPTH/2));
    check("almost_full", 32'(almost_full), 32'(n >= int'(af_th)));
    check("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_th)));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(rd_valid), 32'(n != 0));
    check("data_out", 32'(data_out), (n != 0) ? 32'(q[0]) : 32'd0);
`else
    check("rd_valid", 32'(rd_valid), 32'(exp_rv));
    check("data_out", 32'(data_out), 32'(exp_dout));
`endif
  endtask

  task automatic step(input logic rst_n, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    int  n;
    logic wa, ra;
    @(negedge clk);
    rstn = rst_n; wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_dout = '0; exp_rv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      n  = q.size();
      wa = w && (n < DEPTH);
      ra = r && (n > 0);
      exp_ovf = (exp_ovf && !c) || (w && n == DEPTH);
      exp_unf = (exp_unf && !c) || (r && n == 0);
      exp_rv  = ra;
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; data_in = '0; rd_en = 1'b0; clr_err = 1'b0;
    af_th = 5'd0; ae_th = 5'd3;

    // Reset with requests asserted; almost_full must follow a zero threshold.
    step(0, 1, 8'h11, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    check("rst_almost_full_th0", 32'(almost_full), 32'd1);
    af_th = 5'd12;

    // Fill to full, reject a 17th write, drain in order.
    for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 0, 0);
    check("full_after16", 32'(full), 32'd1);
    check("count_after16", 32'(count), 32'd16);
    step(1, 1, 8'hAA, 0, 0);
    check("ovf_after17", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, 1, 0);
      check("drain_order", 32'(data_out), 32'(i));
    end
    step(1, 0, 8'h00, 0, 1);

    // Interleaved pairs wrap both pointers.
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 8'(8'h40 + i), 0, 0);
      check("pair_cnt_le1", 32'(count <= 5'd1), 32'd1);
      step(1, 0, 8'h00, 1, 0);
      check("pair_data", 32'(data_out), 32'(8'h40 + i));
    end

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hC0 + i), 0, 0);
    step(1, 1, 8'hC5, 1, 0);
    check("simul_count5", 32'(count), 32'd5);
`ifndef SYNC_FIFO_FWFT_EN
    check("simul_rv", 32'(rd_valid), 32'd1);
    check("simul_oldest", 32'(data_out), 32'hC0);
`endif

    // Climb through the half and almost thresholds.
    for (int i = 0; i < 7; i++) step(1, 1, 8'(8'hD0 + i), 0, 0);
    check("af_at12", 32'(almost_full), 32'd1);
    check("hf_at12", 32'(half_full), 32'd1);

    // Drain, underflow, clear, refill to 9 and reset mid-operation.
    while (q.size() > 0) step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    check("unf_set", 32'(underflow), 32'd1);
    step(1, 0, 8'h00, 0, 1);
    check("unf_clr", 32'(underflow), 32'd0);
    step(1, 0, 8'h00, 1, 1);
    check("unf_clr_and_new", 32'(underflow), 32'd1);
    for (int i = 0; i < 9; i++) step(1, 1, 8'(8'hE0 + i), 0, 0);
    step(0, 1, 8'hFF, 1, 0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_unf", 32'(underflow), 32'd0);
    step(1, 1, 8'h3C, 0, 0);
    step(1, 0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_rst_data", 32'(data_out), 32'h3C);
`endif

`ifdef SYNC_FIFO_FWFT_EN
    step(1, 1, 8'h5A, 0, 0);
    check("fwft_show", 32'(data_out), 32'h5A);
    check("fwft_rv", 32'(rd_valid), 32'd1);
    step(1, 0, 8'h00, 1, 0);
    check("fwft_rv_after_ack", 32'(rd_valid), 32'd0);
`endif

    // Randomized traffic with occasional clears, resets and threshold changes.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        af_th = 5'($urandom_range(0, 16));
        ae_th = 5'($urandom_range(0, 16));
      end
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35)),
           8'($urandom),
           ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65)),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
